// File: rtl/l2_mem_arbiter.sv
// l2_mem_arbiter
// Shares the single off-chip memory line port between the instruction-side
// and data-side L2 caches. One request is captured in IDLE, the memory port
// is owned by that requester until mem_ready, the response is passed back
// to the owner in the same cycle, and one DONE cycle follows before the
// next arbitration so that the served cache's stale request is masked.
//
// Ports:
//   clk, proc_reset                  clock, synchronous active-high reset
//   i_read/i_write/i_addr/i_wdata    I-side request (level, held until i_ready)
//   i_rdata/i_ready                  I-side response (ready is a 1-cycle pulse)
//   d_*                              same set for the D side
//   mem_read/mem_write/mem_addr/     registered memory request, driven only
//   mem_wdata                        from the latched request registers
//   mem_rdata/mem_ready              memory response
//   gnt_cnt_i/gnt_cnt_d              per-side grant counters (wrap at 2^32)
module l2_mem_arbiter #(
  parameter int unsigned ADDR_W = 32'd28,
  parameter int unsigned DATA_W = 32'd128,
  parameter bit          RR_EN  = 1'b1
) (
  input  logic              clk,
  input  logic              proc_reset,
  input  logic              i_read,
  input  logic              i_write,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_ready,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ready,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic [31:0]       gnt_cnt_i,
  output logic [31:0]       gnt_cnt_d
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // A side carries a request only when exactly one of read/write is high.
  function automatic logic req_valid(input logic rd, input logic wr);
    return rd ^ wr;
  endfunction

  state_t              state_r;
  logic                owner_d_r;    // 1 = D side owns the port
  logic                op_write_r;
  logic [ADDR_W-1:0]   addr_r;
  logic [DATA_W-1:0]   wdata_r;
  logic                rr_last_d_r;  // 1 = last grant went to D
  logic                mem_read_r;
  logic                mem_write_r;
  logic [31:0]         cnt_i_r;
  logic [31:0]         cnt_d_r;

  logic                i_valid_s;
  logic                d_valid_s;
  logic                grant_s;
  logic                grant_d_s;
  logic                serve_s;

  // Arbitration decision, only meaningful in IDLE.
  always_comb begin
    i_valid_s = req_valid(i_read, i_write);
    d_valid_s = req_valid(d_read, d_write);
    grant_s   = 1'b0;
    grant_d_s = 1'b0;
    if (state_r == ST_IDLE) begin
      grant_s = i_valid_s | d_valid_s;
      if (i_valid_s && d_valid_s) begin
        // Round-robin picks the side that was not served last.
        if (RR_EN) begin
          grant_d_s = ~rr_last_d_r;
        end else begin
          grant_d_s = 1'b1;
        end
      end else begin
        grant_d_s = d_valid_s;
      end
    end else begin
      grant_s   = 1'b0;
      grant_d_s = 1'b0;
    end
  end

  // Memory completion only counts while a transfer is in flight.
  assign serve_s = (state_r == ST_BUSY) && mem_ready;

  // Arbiter FSM, latched request, registered memory strobes and counters.
  always_ff @(posedge clk) begin
    if (proc_reset) begin
      state_r     <= ST_IDLE;
      owner_d_r   <= 1'b0;
      op_write_r  <= 1'b0;
      addr_r      <= {ADDR_W{1'b0}};
      wdata_r     <= {DATA_W{1'b0}};
      rr_last_d_r <= 1'b0;
      mem_read_r  <= 1'b0;
      mem_write_r <= 1'b0;
      cnt_i_r     <= 32'd0;
      cnt_d_r     <= 32'd0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (grant_s) begin
            state_r     <= ST_BUSY;
            owner_d_r   <= grant_d_s;
            rr_last_d_r <= grant_d_s;
            if (grant_d_s) begin
              op_write_r  <= d_write;
              addr_r      <= d_addr;
              wdata_r     <= d_wdata;
              mem_read_r  <= d_read;
              mem_write_r <= d_write;
              cnt_d_r     <= cnt_d_r + 32'd1;
            end else begin
              op_write_r  <= i_write;
              addr_r      <= i_addr;
              wdata_r     <= i_wdata;
              mem_read_r  <= i_read;
              mem_write_r <= i_write;
              cnt_i_r     <= cnt_i_r + 32'd1;
            end
          end
        end
        ST_BUSY: begin
          // Strobes drop the cycle after mem_ready; requester inputs are
          // not looked at here, so the latched request stays stable.
          if (mem_ready) begin
            state_r     <= ST_DONE;
            mem_read_r  <= 1'b0;
            mem_write_r <= 1'b0;
          end
        end
        ST_DONE: begin
          // One dead cycle hides the served cache's stale request.
          state_r <= ST_IDLE;
        end
        default: begin
          state_r     <= ST_IDLE;
          mem_read_r  <= 1'b0;
          mem_write_r <= 1'b0;
        end
      endcase
    end
  end

  // Response routing: ready and read data pass straight through to the owner.
  always_comb begin
    i_ready = 1'b0;
    d_ready = 1'b0;
    i_rdata = {DATA_W{1'b0}};
    d_rdata = {DATA_W{1'b0}};
    if (serve_s) begin
      if (owner_d_r) begin
        d_ready = 1'b1;
        if (!op_write_r) begin
          d_rdata = mem_rdata;
        end else begin
          d_rdata = {DATA_W{1'b0}};
        end
      end else begin
        i_ready = 1'b1;
        if (!op_write_r) begin
          i_rdata = mem_rdata;
        end else begin
          i_rdata = {DATA_W{1'b0}};
        end
      end
    end else begin
      i_ready = 1'b0;
      d_ready = 1'b0;
    end
  end

  assign mem_read  = mem_read_r;
  assign mem_write = mem_write_r;
  assign mem_addr  = addr_r;
  assign mem_wdata = wdata_r;
  assign gnt_cnt_i = cnt_i_r;
  assign gnt_cnt_d = cnt_d_r;

endmodule

// File: tb/tb_l2_mem_arbiter.sv
// Bench for l2_mem_arbiter: two instances (index 0 round-robin, index 1
// fixed D priority) checked every cycle against a transaction-level model,
// with directed scenarios pinned by literal expectations followed by a
// randomized phase (random requesters, random-latency memory, spurious
// mem_ready pulses, occasional resets).
module tb_l2_mem_arbiter;
  localparam int AW = 28;
  localparam int DW = 128;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          proc_reset;
  logic          i_read [2], i_write [2], d_read [2], d_write [2];
  logic [AW-1:0] i_addr [2], d_addr [2];
  logic [DW-1:0] i_wdata [2], d_wdata [2], mem_rdata [2];
  logic          mem_ready [2];
  logic [DW-1:0] i_rdata [2], d_rdata [2], mem_wdata [2];
  logic          i_ready [2], d_ready [2], mem_read [2], mem_write [2];
  logic [AW-1:0] mem_addr [2];
  logic [31:0]   gnt_cnt_i [2], gnt_cnt_d [2];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    l2_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RR_EN(g == 0)) u_dut (
      .clk(clk), .proc_reset(proc_reset),
      .i_read(i_read[g]), .i_write(i_write[g]), .i_addr(i_addr[g]),
      .i_wdata(i_wdata[g]), .i_rdata(i_rdata[g]), .i_ready(i_ready[g]),
      .d_read(d_read[g]), .d_write(d_write[g]), .d_addr(d_addr[g]),
      .d_wdata(d_wdata[g]), .d_rdata(d_rdata[g]), .d_ready(d_ready[g]),
      .mem_read(mem_read[g]), .mem_write(mem_write[g]), .mem_addr(mem_addr[g]),
      .mem_wdata(mem_wdata[g]), .mem_rdata(mem_rdata[g]), .mem_ready(mem_ready[g]),
      .gnt_cnt_i(gnt_cnt_i[g]), .gnt_cnt_d(gnt_cnt_d[g])
    );
  end

  int n_tests, n_fail;
  bit cmp_en;

  // Transaction-level model: an in-flight transfer, a one-cycle cooldown
  // after completion, who was served last, and grant tallies.
  bit            m_busy [2], m_cool [2], m_owner_d [2], m_wr [2], m_last_d [2];
  logic [AW-1:0] m_addr [2];
  logic [DW-1:0] m_wdata [2];
  logic [31:0]   m_ci [2], m_cd [2];
  bit            rr_mode [2] = '{1'b1, 1'b0};

  // Random-phase stimulus state (side 0 = I, side 1 = D).
  bit            g_act [2][2], g_stale [2][2], g_inv [2][2], prev_rdy [2][2];
  int            lat [2];

  task automatic chk(input string nm, input int k, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s dut%0d: actual %h required %h (t=%0t)", nm, k, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    for (int k = 0; k < 2; k++) begin
      logic er, ew, eir, edr;
      er  = m_busy[k] && !m_wr[k];
      ew  = m_busy[k] && m_wr[k];
      eir = m_busy[k] && mem_ready[k] && !m_owner_d[k];
      edr = m_busy[k] && mem_ready[k] && m_owner_d[k];
      chk("mem_read", k, mem_read[k], er);
      chk("mem_write", k, mem_write[k], ew);
      if (m_busy[k]) chk("mem_addr", k, mem_addr[k], m_addr[k]);
      if (ew) chk("mem_wdata", k, mem_wdata[k], m_wdata[k]);
      chk("i_ready", k, i_ready[k], eir);
      chk("d_ready", k, d_ready[k], edr);
      chk("i_rdata", k, i_rdata[k], (eir && !m_wr[k]) ? mem_rdata[k] : '0);
      chk("d_rdata", k, d_rdata[k], (edr && !m_wr[k]) ? mem_rdata[k] : '0);
      chk("gnt_cnt_i", k, gnt_cnt_i[k], m_ci[k]);
      chk("gnt_cnt_d", k, gnt_cnt_d[k], m_cd[k]);
    end
  endtask

  task automatic model_step();
    for (int k = 0; k < 2; k++) begin
      bit iv, dv, pick_d;
      iv = i_read[k] ^ i_write[k];
      dv = d_read[k] ^ d_write[k];
      if (proc_reset) begin
        m_busy[k] = 0; m_cool[k] = 0; m_owner_d[k] = 0; m_wr[k] = 0;
        m_last_d[k] = 0; m_ci[k] = 0; m_cd[k] = 0;
      end else if (m_busy[k]) begin
        if (mem_ready[k]) begin m_busy[k] = 0; m_cool[k] = 1; end
      end else if (m_cool[k]) begin
        m_cool[k] = 0;
      end else if (iv || dv) begin
        pick_d = dv && (!iv || !rr_mode[k] || !m_last_d[k]);
        m_busy[k] = 1; m_owner_d[k] = pick_d; m_last_d[k] = pick_d;
        if (pick_d) begin
          m_wr[k] = d_write[k]; m_addr[k] = d_addr[k]; m_wdata[k] = d_wdata[k]; m_cd[k] = m_cd[k] + 1;
        end else begin
          m_wr[k] = i_write[k]; m_addr[k] = i_addr[k]; m_wdata[k] = i_wdata[k]; m_ci[k] = m_ci[k] + 1;
        end
      end
    end
  endtask

  // Called just after a falling edge with this cycle's inputs in place.
  task automatic cycle();
    #1;
    if (cmp_en) compare_all();
    model_step();
  endtask

  task automatic drive_i(input logic rd, input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] w);
    for (int k = 0; k < 2; k++) begin i_read[k] = rd; i_write[k] = wr; i_addr[k] = a; i_wdata[k] = w; end
  endtask

  task automatic drive_d(input logic rd, input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] w);
    for (int k = 0; k < 2; k++) begin d_read[k] = rd; d_write[k] = wr; d_addr[k] = a; d_wdata[k] = w; end
  endtask

  task automatic mem_set(input logic r, input logic [DW-1:0] d);
    for (int k = 0; k < 2; k++) begin mem_ready[k] = r; mem_rdata[k] = d; end
  endtask

  // Memory that answers on the first strobe cycle.
  task automatic mem_auto();
    for (int k = 0; k < 2; k++) begin
      mem_ready[k] = mem_read[k] | mem_write[k];
      mem_rdata[k] = {4{32'hC0DE0000 + 32'(k)}};
    end
  endtask

  task automatic set_side(input int k, input int s, input logic rd, input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] w);
    if (s == 0) begin i_read[k] = rd; i_write[k] = wr; i_addr[k] = a; i_wdata[k] = w; end
    else begin d_read[k] = rd; d_write[k] = wr; d_addr[k] = a; d_wdata[k] = w; end
  endtask

  task automatic new_req(input int k, input int s);
    int kind;
    kind = $urandom_range(0, 7);
    g_act[k][s] = 1;
    g_inv[k][s] = (kind == 0);
    set_side(k, s, (kind == 0) || (kind > 3), (kind <= 3), AW'($urandom),
             {$urandom, $urandom, $urandom, $urandom});
  endtask

  task automatic gen_update(input int k, input int s);
    if (prev_rdy[k][s]) begin
      if ($urandom_range(0, 3) == 0) new_req(k, s);
      else g_stale[k][s] = 1;
    end else if (g_stale[k][s]) begin
      g_stale[k][s] = 0;
      if ($urandom_range(0, 1) == 0) new_req(k, s);
      else begin g_act[k][s] = 0; set_side(k, s, 0, 0, '0, '0); end
    end else if (g_act[k][s]) begin
      if (g_inv[k][s] && $urandom_range(0, 3) == 0) begin
        g_act[k][s] = 0; set_side(k, s, 0, 0, '0, '0);
      end else if ($urandom_range(0, 15) == 0) begin
        if (s == 0) i_addr[k] = AW'($urandom); else d_addr[k] = AW'($urandom);
      end
    end else if ($urandom_range(0, 2) == 0) begin
      new_req(k, s);
    end
  endtask

  logic [DW-1:0] a5;

  initial begin
    n_tests = 0; n_fail = 0; cmp_en = 0;
    a5 = {16{8'hA5}};
    proc_reset = 1;
    drive_i(0, 0, '0, '0); drive_d(0, 0, '0, '0); mem_set(0, '0);
    for (int k = 0; k < 2; k++) begin lat[k] = 0; for (int s = 0; s < 2; s++) begin g_act[k][s] = 0; g_stale[k][s] = 0; g_inv[k][s] = 0; prev_rdy[k][s] = 0; end end

    // Reset state
    @(negedge clk); cycle();
    @(negedge clk); cmp_en = 1; cycle();
    for (int k = 0; k < 2; k++) begin
      chk("rst_mem_read", k, mem_read[k], 1'b0); chk("rst_mem_write", k, mem_write[k], 1'b0);
      chk("rst_mem_addr", k, mem_addr[k], '0); chk("rst_mem_wdata", k, mem_wdata[k], '0);
      chk("rst_cnt_i", k, gnt_cnt_i[k], 32'd0); chk("rst_cnt_d", k, gnt_cnt_d[k], 32'd0);
    end
    @(negedge clk); proc_reset = 0;

    // Single I read, memory answers on third strobe cycle
    drive_i(1, 0, 28'h10, '0); cycle();
    for (int k = 0; k < 2; k++) chk("t1_no_strobe_T", k, mem_read[k], 1'b0);
    @(negedge clk); cycle();
    for (int k = 0; k < 2; k++) begin chk("t1_rd_T1", k, mem_read[k], 1'b1); chk("t1_addr", k, mem_addr[k], 28'h10); end
    @(negedge clk); cycle();
    @(negedge clk); mem_set(1, a5); cycle();
    for (int k = 0; k < 2; k++) begin
      chk("t1_i_ready", k, i_ready[k], 1'b1); chk("t1_i_rdata", k, i_rdata[k], a5); chk("t1_d_ready", k, d_ready[k], 1'b0);
    end
    @(negedge clk); mem_set(0, '0); cycle();
    for (int k = 0; k < 2; k++) begin chk("t1_done_rd", k, mem_read[k], 1'b0); chk("t1_done_rdy", k, i_ready[k], 1'b0); end
    @(negedge clk); drive_i(0, 0, '0, '0); cycle();
    for (int k = 0; k < 2; k++) chk("t1_cnt_i", k, gnt_cnt_i[k], 32'd1);

    // Simultaneous I read / D write after reset: D goes first
    @(negedge clk); proc_reset = 1; cycle();
    @(negedge clk); proc_reset = 0;
    drive_i(1, 0, 28'h20, '0); drive_d(0, 1, 28'h30, 128'h1234); cycle();
    @(negedge clk); cycle();
    for (int k = 0; k < 2; k++) begin
      chk("t2_d_wr", k, mem_write[k], 1'b1); chk("t2_d_addr", k, mem_addr[k], 28'h30);
      chk("t2_d_wdata", k, mem_wdata[k], 128'h1234); chk("t2_no_rd", k, mem_read[k], 1'b0);
    end
    @(negedge clk); mem_set(1, 128'hDEAD); cycle();
    for (int k = 0; k < 2; k++) begin
      chk("t2_d_ready", k, d_ready[k], 1'b1); chk("t2_wr_rdata", k, d_rdata[k], '0); chk("t2_i_quiet", k, i_ready[k], 1'b0);
    end
    @(negedge clk); mem_set(0, '0); cycle();
    for (int k = 0; k < 2; k++) begin chk("t2_done_wr", k, mem_write[k], 1'b0); chk("t2_done_rd", k, mem_read[k], 1'b0); end
    @(negedge clk); drive_d(0, 0, '0, '0); cycle();
    @(negedge clk); cycle();
    for (int k = 0; k < 2; k++) begin chk("t2_i_rd", k, mem_read[k], 1'b1); chk("t2_i_addr", k, mem_addr[k], 28'h20); end
    @(negedge clk); mem_set(1, 128'hBEEF); cycle();
    for (int k = 0; k < 2; k++) begin chk("t2_i_ready", k, i_ready[k], 1'b1); chk("t2_i_rdata", k, i_rdata[k], 128'hBEEF); end
    @(negedge clk); mem_set(0, '0); drive_i(0, 0, '0, '0); cycle();
    for (int k = 0; k < 2; k++) begin chk("t2_cnt_i", k, gnt_cnt_i[k], 32'd1); chk("t2_cnt_d", k, gnt_cnt_d[k], 32'd1); end

    // Continuous D and I requests: round-robin vs fixed D priority
    @(negedge clk); proc_reset = 1; cycle();
    @(negedge clk); proc_reset = 0;
    drive_i(1, 0, 28'h100, '0); drive_d(1, 0, 28'h200, '0);
    repeat (9) begin mem_auto(); cycle(); @(negedge clk); end
    chk("t3_rr_cnt_d", 0, gnt_cnt_d[0], 32'd2); chk("t3_rr_cnt_i", 0, gnt_cnt_i[0], 32'd1);
    chk("t3_fp_cnt_d", 1, gnt_cnt_d[1], 32'd3); chk("t3_fp_cnt_i", 1, gnt_cnt_i[1], 32'd0);
    drive_d(0, 0, '0, '0);
    repeat (3) begin mem_auto(); cycle(); @(negedge clk); end
    chk("t3_fp_i_late", 1, gnt_cnt_i[1], 32'd1); chk("t3_rr_i_late", 0, gnt_cnt_i[0], 32'd2);
    drive_i(0, 0, '0, '0); mem_auto(); cycle();

    // Write-back then read, stale read held one cycle after ready
    @(negedge clk); proc_reset = 1; mem_set(0, '0); cycle();
    @(negedge clk); proc_reset = 0;
    drive_d(0, 1, 28'h40, 128'h77); mem_auto(); cycle();
    @(negedge clk); mem_auto(); cycle();
    for (int k = 0; k < 2; k++) begin chk("t4_wb_wr", k, mem_write[k], 1'b1); chk("t4_wb_addr", k, mem_addr[k], 28'h40); end
    @(negedge clk); drive_d(1, 0, 28'h50, '0); mem_auto(); cycle();
    for (int k = 0; k < 2; k++) begin chk("t4_gap_rd", k, mem_read[k], 1'b0); chk("t4_gap_wr", k, mem_write[k], 1'b0); end
    @(negedge clk); mem_auto(); cycle();
    for (int k = 0; k < 2; k++) chk("t4_idle_rd", k, mem_read[k], 1'b0);
    @(negedge clk); mem_auto(); cycle();
    for (int k = 0; k < 2; k++) begin chk("t4_rd", k, mem_read[k], 1'b1); chk("t4_rd_addr", k, mem_addr[k], 28'h50); end
    @(negedge clk); mem_auto(); cycle();
    for (int k = 0; k < 2; k++) chk("t4_stale_masked", k, mem_read[k], 1'b0);
    @(negedge clk); drive_d(0, 0, '0, '0); mem_auto(); cycle();
    for (int k = 0; k < 2; k++) begin chk("t4_no_reissue", k, mem_read[k], 1'b0); chk("t4_cnt_d", k, gnt_cnt_d[k], 32'd2); end

    // Reset during BUSY, late mem_ready dropped; invalid request never granted
    @(negedge clk); proc_reset = 1; mem_set(0, '0); cycle();
    @(negedge clk); proc_reset = 0; drive_d(1, 0, 28'h70, '0); cycle();
    @(negedge clk); proc_reset = 1; cycle();
    for (int k = 0; k < 2; k++) chk("t5_busy_rd", k, mem_read[k], 1'b1);
    @(negedge clk); proc_reset = 0; drive_d(0, 0, '0, '0); mem_set(1, a5); cycle();
    for (int k = 0; k < 2; k++) begin
      chk("t5_rst_rd", k, mem_read[k], 1'b0); chk("t5_late_rdy", k, d_ready[k], 1'b0); chk("t5_cnt_d", k, gnt_cnt_d[k], 32'd0);
    end
    @(negedge clk); mem_set(0, '0); drive_i(1, 1, 28'h80, '0); cycle();
    repeat (5) begin
      @(negedge clk); mem_auto(); cycle();
      for (int k = 0; k < 2; k++) begin chk("t5_inv_rd", k, mem_read[k], 1'b0); chk("t5_inv_cnt", k, gnt_cnt_i[k], 32'd0); end
    end
    @(negedge clk); drive_i(0, 0, '0, '0); mem_set(0, '0); cycle();

    // Randomized phase
    repeat (3000) begin
      @(negedge clk);
      proc_reset = ($urandom_range(0, 299) == 0);
      for (int k = 0; k < 2; k++) begin
        gen_update(k, 0); gen_update(k, 1);
        if (mem_read[k] || mem_write[k]) begin
          if (lat[k] == 0) lat[k] = $urandom_range(1, 4);
          lat[k]--;
          mem_ready[k] = (lat[k] == 0);
        end else begin
          lat[k] = 0;
          mem_ready[k] = ($urandom_range(0, 7) == 0);
        end
        mem_rdata[k] = {$urandom, $urandom, $urandom, $urandom};
      end
      cycle();
      for (int k = 0; k < 2; k++) begin prev_rdy[k][0] = i_ready[k]; prev_rdy[k][1] = d_ready[k]; end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
